// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS registers with byte-strobed writes and a flattened contents port.
// Build option: define AXI4_LITE_REG_BANK_ID_EN to echo AWID on BID and ARID on RID (IDs read as zero otherwise).
module axi4_lite_reg_bank #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [ID_WIDTH-1:0]            s_awid,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [2:0]                     s_awprot,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [ID_WIDTH-1:0]            s_bid,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ID_WIDTH-1:0]            s_arid,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [2:0]                     s_arprot,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [ID_WIDTH-1:0]            s_rid,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_stb_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic       W_COLLECT   = 1'b0;
  localparam logic       W_RESP      = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  state_r;
  logic                  aw_held_r;
  logic                  w_held_r;
  logic [IDX_WIDTH-1:0]  aw_idx_r;
  logic                  aw_in_range_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] wstrb_r;
  logic [1:0]            bresp_r;
  logic                  rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;
  logic [NUM_REGS-1:0]   wr_stb_r;
  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] aw_word, ar_word;
  logic                  aw_in_range, ar_in_range;
  logic [IDX_WIDTH-1:0]  cur_idx;
  logic                  cur_in_range;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [STRB_WIDTH-1:0] cur_strb;

  assign aw_word     = s_awaddr >> OFFS;
  assign ar_word     = s_araddr >> OFFS;
  assign aw_in_range = (aw_word < ADDR_WIDTH'(NUM_REGS));
  assign ar_in_range = (ar_word < ADDR_WIDTH'(NUM_REGS));

  assign s_awready = !aw_held_r && (state_r == W_COLLECT);
  assign s_wready  = !w_held_r && (state_r == W_COLLECT);
  assign s_arready = !rvalid_r;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign ar_hs     = s_arvalid && s_arready;
  // A half arriving this cycle completes the pair, so a burst commits every other cycle.
  assign commit    = (state_r == W_COLLECT) && (aw_held_r || aw_hs) && (w_held_r || w_hs);

  assign s_bvalid = (state_r == W_RESP);
  assign s_bresp  = bresp_r;
  assign s_rvalid = rvalid_r;
  assign s_rdata  = rdata_r;
  assign s_rresp  = rresp_r;
  assign wr_stb_o = wr_stb_r;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_r[k];
  end

  // Select the write target and payload from either the held copy or the live channel.
  always_comb begin
    cur_idx      = aw_idx_r;
    cur_in_range = aw_in_range_r;
    cur_data     = wdata_r;
    cur_strb     = wstrb_r;
    if (aw_held_r) begin
      cur_idx      = aw_idx_r;
      cur_in_range = aw_in_range_r;
    end else begin
      cur_idx      = aw_word[IDX_WIDTH-1:0];
      cur_in_range = aw_in_range;
    end
    if (w_held_r) begin
      cur_data = wdata_r;
      cur_strb = wstrb_r;
    end else begin
      cur_data = s_wdata;
      cur_strb = s_wstrb;
    end
  end

  // Hold AW and W independently until both halves of a write are present.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aw_held_r     <= 1'b0;
      w_held_r      <= 1'b0;
      aw_idx_r      <= '0;
      aw_in_range_r <= 1'b0;
      wdata_r       <= '0;
      wstrb_r       <= '0;
    end else if (commit) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_r     <= 1'b1;
        aw_idx_r      <= aw_word[IDX_WIDTH-1:0];
        aw_in_range_r <= aw_in_range;
      end
      if (w_hs) begin
        w_held_r <= 1'b1;
        wdata_r  <= s_wdata;
        wstrb_r  <= s_wstrb;
      end
    end
  end

  // Write response FSM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= W_COLLECT;
      bresp_r <= 2'b00;
    end else begin
      case (state_r)
        W_COLLECT: begin
          if (commit) begin
            state_r <= W_RESP;
            bresp_r <= cur_in_range ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (s_bready) state_r <= W_COLLECT;
        end
        default: state_r <= W_COLLECT;
      endcase
    end
  end

  // Register file with per-lane strobes and a one-cycle update pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_REGS; k++) regs_r[k] <= '0;
      wr_stb_r <= '0;
    end else begin
      wr_stb_r <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit && cur_in_range && (cur_idx == IDX_WIDTH'(k))) begin
          wr_stb_r[k] <= 1'b1;
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (cur_strb[b]) regs_r[k][8*b +: 8] <= cur_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read path samples the register file before any same-edge write lands.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_r <= 1'b1;
      rdata_r  <= ar_in_range ? regs_r[ar_word[IDX_WIDTH-1:0]] : '0;
      rresp_r  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_r && s_rready) begin
      rvalid_r <= 1'b0;
    end
  end

`ifdef AXI4_LITE_REG_BANK_ID_EN
  logic [ID_WIDTH-1:0] awid_r, bid_r, rid_r;
  logic                unused;

  // ID echo storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      awid_r <= '0;
      bid_r  <= '0;
      rid_r  <= '0;
    end else begin
      if (aw_hs) awid_r <= s_awid;
      if (commit) bid_r <= aw_held_r ? awid_r : s_awid;
      if (ar_hs) rid_r <= s_arid;
    end
  end

  assign s_bid  = bid_r;
  assign s_rid  = rid_r;
  assign unused = ^{s_awprot, s_arprot, s_awaddr[OFFS-1:0], s_araddr[OFFS-1:0]};
`else
  logic unused;
  assign s_bid  = '0;
  assign s_rid  = '0;
  assign unused = ^{s_awid, s_arid, s_awprot, s_arprot, s_awaddr[OFFS-1:0], s_araddr[OFFS-1:0]};
`endif

endmodule

// File: doc/axi4_lite_reg_bank.md
AXI4_LITE_REG_BANK -- requirements
Module: axi4_lite_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI4-Lite byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, legal values 32 and 64.
REQ-003 SHALL have parameter NUM_REGS, default 16: register count, range 1..256.
REQ-004 SHALL have parameter ID_WIDTH, default 4: width of the AXI ID fields.
REQ-005 SHALL have ports clk_i (in, 1, clock) and rst_n_i (in, 1, reset). One clock domain. rst_n_i is asynchronous and active-low.
REQ-006 SHALL have AW-channel ports: s_awid (in, ID_WIDTH), s_awaddr (in, ADDR_WIDTH), s_awprot (in, 3), s_awvalid (in, 1), s_awready (out, 1).
REQ-007 SHALL have W-channel ports: s_wdata (in, DATA_WIDTH), s_wstrb (in, DATA_WIDTH/8), s_wvalid (in, 1), s_wready (out, 1).
REQ-008 SHALL have B-channel ports: s_bid (out, ID_WIDTH), s_bresp (out, 2), s_bvalid (out, 1), s_bready (in, 1).
REQ-009 SHALL have AR-channel ports: s_arid (in, ID_WIDTH), s_araddr (in, ADDR_WIDTH), s_arprot (in, 3), s_arvalid (in, 1), s_arready (out, 1).
REQ-010 SHALL have R-channel ports: s_rid (out, ID_WIDTH), s_rdata (out, DATA_WIDTH), s_rresp (out, 2), s_rvalid (out, 1), s_rready (in, 1).
REQ-011 SHALL have regs_o (out, NUM_REGS*DATA_WIDTH): flattened register contents; register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have wr_stb_o (out, NUM_REGS): one-cycle pulse per register, set in the cycle the register is updated.

Function
REQ-013 SHALL decode word index = addr >> log2(DATA_WIDTH/8); the address is in range iff index < NUM_REGS; low address bits are ignored.
REQ-014 SHALL latch AW and W independently. s_awready = 1 while no AW is held and no B response is pending; s_wready uses the same rule for W.
REQ-015 Write FSM states: W_COLLECT (waiting for AW, W or both) -> W_RESP (s_bvalid = 1) -> W_COLLECT on s_bvalid && s_bready.
REQ-016 SHALL enter W_RESP on the cycle after both AW and W are held. AW and W may arrive in the same cycle or in either order, any cycles apart.
REQ-017 On entry to W_RESP, an in-range write SHALL update the register byte lanes whose s_wstrb bit is 1, leave the other lanes unchanged, and pulse wr_stb_o[index]; s_bresp = OKAY (2'b00).
REQ-018 An out-of-range write SHALL modify no register and raise no wr_stb_o; s_bresp = SLVERR (2'b10).
REQ-019 SHALL hold s_bvalid, s_bresp and s_bid stable until s_bready is 1; a write burst with s_bready held at 1 sustains one write per 2 cycles.
REQ-020 Read path: s_arready = !s_rvalid. An AR handshake SHALL register s_rdata and s_rresp and set s_rvalid on the next edge (1-cycle latency). These hold until s_rready.
REQ-021 An out-of-range read SHALL return s_rdata = 0 with s_rresp = SLVERR.
REQ-022 A read and a write to the same register accepted in the same cycle: the read SHALL return the pre-write value.
REQ-023 s_awprot and s_arprot SHALL be accepted and ignored.
REQ-024 The read and write paths SHALL be fully independent; neither stalls the other.

Reset
REQ-025 While rst_n_i = 0: all registers = 0, s_bvalid = s_rvalid = 0, s_bresp = s_rresp = 0, s_rdata = 0, s_bid = s_rid = 0, wr_stb_o = 0, held AW/W flags cleared, FSM = W_COLLECT.
REQ-026 s_awready, s_wready and s_arready SHALL be 1 from the first edge after reset release.
REQ-027 Reset asserted mid-transaction SHALL discard all pending AW, W, B and R state with no partial register update.

Configuration
REQ-028 With AXI4_LITE_REG_BANK_ID_EN defined: s_bid SHALL echo the s_awid of the write, and s_rid SHALL echo the s_arid of the read.
REQ-029 With AXI4_LITE_REG_BANK_ID_EN undefined: s_bid = s_rid = 0 constantly, the s_awid/s_arid inputs are unused, and no ID storage is generated.

Verification
REQ-030 AW and W in the same cycle (addr 0x08, data 0xDEADBEEF, strb 4'hF), s_bready = 1 -> s_bvalid 1 cycle later, s_bresp = 0, regs_o reg 2 = 0xDEADBEEF, wr_stb_o[2] pulses once.
REQ-031 W sent 3 cycles before AW (addr 0x04, data 0x12345678, strb 4'b0101), reg 1 = 0 beforehand -> reg 1 = 0x00340078.
REQ-032 Write to addr 0x40 with NUM_REGS = 16 -> s_bresp = 2'b10, all registers unchanged; read of 0x40 -> s_rdata = 0, s_rresp = 2'b10.
REQ-033 s_rready held 0 for 5 cycles after a read of reg 2 -> s_rvalid, s_rdata = 0xDEADBEEF and s_rid stay stable, s_arready = 0 throughout.
REQ-034 Same-cycle read and write of reg 2 (new data 0x1) -> s_rdata = 0xDEADBEEF, then reg 2 = 0x1.
REQ-035 With ID_EN defined: awid = 4'hA, arid = 4'h5 -> s_bid = 4'hA, s_rid = 4'h5. rst_n_i pulsed low while s_bvalid = 1 -> s_bvalid = 0 and all registers = 0.
